// File: rtl/uart_tx_controller_if.sv
// =============================================================================
// uart_tx_controller_if : host handshake, datapath control and serial line
// Revision : 1.0
// =============================================================================
`default_nettype none

interface uart_tx_controller_if;
  logic       TX_Start;
  logic       TX_Ready;
  logic       TX_Busy;
  logic       TX_Done;
  logic       TX_Serial_out;
  logic       Bit_Count_Reached;
  logic       TX_Data_out;
  logic       Bit_Counter_sel;
  logic [1:0] TX_Shift_Register_sel;

  // Controller side
  modport master (
    input  TX_Start,
    input  Bit_Count_Reached,
    input  TX_Data_out,
    output TX_Ready,
    output TX_Busy,
    output TX_Done,
    output TX_Serial_out,
    output Bit_Counter_sel,
    output TX_Shift_Register_sel
  );

  // Host / datapath / pin side
  modport slave (
    output TX_Start,
    output Bit_Count_Reached,
    output TX_Data_out,
    input  TX_Ready,
    input  TX_Busy,
    input  TX_Done,
    input  TX_Serial_out,
    input  Bit_Counter_sel,
    input  TX_Shift_Register_sel
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_controller.sv
// =============================================================================
// uart_tx_controller : UART TX sequencing FSM (start / data / [parity] / stop)
// Define UART_TX_PARITY_EN to add an even-parity bit.   Revision : 1.0
// =============================================================================
`default_nettype none

module uart_tx_controller #(
  parameter int WORD_SIZE          = 8,
  parameter int CLKS_PER_BIT       = 868,
  parameter int CLKS_PER_BIT_WIDTH = 10,
  parameter int STOP_BITS          = 1
) (
  input  wire logic            clk,
  input  wire logic            reset_b,
  uart_tx_controller_if.master tx
);

  localparam int BIT_IDX_W = (WORD_SIZE > 2) ? $clog2(WORD_SIZE) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t                        r_state;
  state_t                        w_next_state;
  logic [CLKS_PER_BIT_WIDTH-1:0] r_baud_cnt;
  logic [BIT_IDX_W-1:0]          r_bit_idx;
  logic                          w_bit_end;
  logic                          w_data_last;
  logic                          w_stop_last;
`ifdef UART_TX_PARITY_EN
  logic                          r_parity;
`endif

  assign w_bit_end   = (r_baud_cnt == CLKS_PER_BIT_WIDTH'(CLKS_PER_BIT - 1));
  // The local period index backs up the datapath counter so DATA never
  // overruns WORD_SIZE bit periods.
  assign w_data_last = tx.Bit_Count_Reached ||
                       (r_bit_idx == BIT_IDX_W'(WORD_SIZE - 1));
  assign w_stop_last = (r_bit_idx == BIT_IDX_W'(STOP_BITS - 1));

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
    end else begin
      r_state <= w_next_state;

      if ((r_state == S_IDLE) || (w_next_state != r_state) || w_bit_end) begin
        r_baud_cnt <= '0;
      end else begin
        r_baud_cnt <= r_baud_cnt + CLKS_PER_BIT_WIDTH'(1);
      end

      if (w_next_state != r_state) begin
        r_bit_idx <= '0;
      end else if (w_bit_end) begin
        r_bit_idx <= r_bit_idx + BIT_IDX_W'(1);
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_parity <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_parity <= 1'b0;
    end else if ((r_state == S_DATA) && w_bit_end) begin
      r_parity <= r_parity ^ tx.TX_Data_out;
    end
  end
`endif

  always_comb begin
    w_next_state             = r_state;
    tx.TX_Ready              = 1'b0;
    tx.TX_Busy               = 1'b1;
    tx.TX_Done               = 1'b0;
    tx.TX_Serial_out         = 1'b1;
    tx.Bit_Counter_sel       = 1'b0;
    tx.TX_Shift_Register_sel = 2'b00;

    case (r_state)
      S_IDLE: begin
        tx.TX_Ready = 1'b1;
        tx.TX_Busy  = 1'b0;
        if (tx.TX_Start) begin
          tx.TX_Shift_Register_sel = 2'b01;
          w_next_state             = S_START;
        end
      end

      S_START: begin
        tx.TX_Serial_out = 1'b0;
        if (w_bit_end) begin
          w_next_state = S_DATA;
        end
      end

      S_DATA: begin
        tx.TX_Serial_out = tx.TX_Data_out;
        if (w_bit_end) begin
          if (w_data_last) begin
`ifdef UART_TX_PARITY_EN
            w_next_state = S_PARITY;
`else
            w_next_state = S_STOP;
`endif
          end else begin
            tx.TX_Shift_Register_sel = 2'b10;
            tx.Bit_Counter_sel       = 1'b1;
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        tx.TX_Serial_out = r_parity;
        if (w_bit_end) begin
          w_next_state = S_STOP;
        end
      end
`endif

      S_STOP: begin
        if (w_bit_end && w_stop_last) begin
          tx.TX_Done   = 1'b1;
          w_next_state = S_IDLE;
        end
      end

      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_controller.sv
// =============================================================================
// tb_uart_tx_controller : directed bench, two controllers (1 and 2 stop bits)
// Revision : 1.0
// =============================================================================
`default_nettype none

module tb_uart_tx_controller;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  logic clk     = 1'b0;
  logic reset_b = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]      tx_start = '0;
  logic [1:0][7:0] tx_data  = '0;
  logic [1:0]      line, ready, busy, done, bc_sel;
  logic [1:0][1:0] sr_sel;

  int tests_run    = 0;
  int tests_failed = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    uart_tx_controller_if bus ();
    logic [7:0] sr;
    logic [3:0] cnt;

    uart_tx_controller #(
      .WORD_SIZE         (8),
      .CLKS_PER_BIT      (CPB),
      .CLKS_PER_BIT_WIDTH(3),
      .STOP_BITS         (g + 1)
    ) u_dut (
      .clk    (clk),
      .reset_b(reset_b),
      .tx     (bus)
    );

    // Datapath stand-in: shift register and bit counter
    always_ff @(posedge clk) begin
      if (bus.TX_Shift_Register_sel == 2'b01) begin
        sr  <= tx_data[g];
        cnt <= '0;
      end else if (bus.TX_Shift_Register_sel == 2'b10) begin
        sr <= {1'b0, sr[7:1]};
      end
      if (bus.Bit_Counter_sel) cnt <= cnt + 4'd1;
    end

    assign bus.TX_Start          = tx_start[g];
    assign bus.TX_Data_out       = sr[0];
    assign bus.Bit_Count_Reached = (cnt == 4'd7);
    assign line[g]   = bus.TX_Serial_out;
    assign ready[g]  = bus.TX_Ready;
    assign busy[g]   = bus.TX_Busy;
    assign done[g]   = bus.TX_Done;
    assign bc_sel[g] = bus.Bit_Counter_sel;
    assign sr_sel[g] = bus.TX_Shift_Register_sel;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // All tasks are entered and left 1 time unit after a rising edge
  task automatic wait_ready(input int idx);
    int n = 0;
    while (!ready[idx] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready[idx]) check("ready_timeout", 32'(ready[idx]), 1);
  endtask

  task automatic start_frame(input int idx, input logic [7:0] data);
    wait_ready(idx);
    tx_data[idx]  = data;
    tx_start[idx] = 1'b1;
    #1;
    check("load_sel", 32'(sr_sel[idx]), 2'b01);
    @(posedge clk); #1;
    tx_start[idx] = 1'b0;
  endtask

  task automatic observe_frame(input int idx, input logic [7:0] data,
                               input int pulse_at, input bit hold);
    int nbits = 1 + 8 + PAR_BITS + idx + 1;
    int len   = nbits * CPB;
    logic [11:0] bits;
    int bad = 0, not_busy = 0, done_cnt = 0, done_at = -1;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = data[i];
    if (PAR_BITS == 1) bits[9] = ^data;
    for (int c = 1; c <= len; c++) begin
      if (c == pulse_at) tx_start[idx] = 1'b1;
      else if (c == pulse_at + 1 && !hold) tx_start[idx] = 1'b0;
      if (line[idx] !== bits[(c-1)/CPB]) bad++;
      if (!busy[idx] || ready[idx]) not_busy++;
      if (done[idx]) begin
        done_cnt++;
        done_at = c;
      end
      @(posedge clk); #1;
    end
    if (pulse_at == len && !hold) tx_start[idx] = 1'b0;
    check($sformatf("line_%0d_%02h", idx, data), 32'(bad), 0);
    check("busy_in_frame", 32'(not_busy), 0);
    check("done_count", 32'(done_cnt), 1);
    check("done_cycle", 32'(done_at), 32'(len));
    check("ready_after", 32'(ready[idx]), 1);
    check("busy_after", 32'(busy[idx]), 0);
  endtask

  task automatic idle_check(input int idx, input int n, input string tag);
    int bad = 0;
    for (int c = 0; c < n; c++) begin
      if (busy[idx] || !line[idx] || !ready[idx]) bad++;
      @(posedge clk); #1;
    end
    check(tag, 32'(bad), 0);
  endtask

  task automatic reset_values(input string tag);
    check({tag, "_line"},  32'(line[0]),   1);
    check({tag, "_ready"}, 32'(ready[0]),  1);
    check({tag, "_busy"},  32'(busy[0]),   0);
    check({tag, "_done"},  32'(done[0]),   0);
    check({tag, "_bcsel"}, 32'(bc_sel[0]), 0);
    check({tag, "_srsel"}, 32'(sr_sel[0]), 0);
  endtask

  initial begin
    #2 reset_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_values("rst");
    reset_b = 1'b1;
    @(posedge clk); #1;

    // Basic frame, LSB first
    start_frame(0, 8'hA5);
    observe_frame(0, 8'hA5, 0, 1'b0);

    // Back-to-back: start held through TX_Done, accepted the cycle after
    start_frame(0, 8'h00);
    tx_data[0] = 8'h3C;
    observe_frame(0, 8'h00, (10 + PAR_BITS) * CPB, 1'b1);
    check("b2b_load", 32'(sr_sel[0]), 2'b01);
    @(posedge clk); #1;
    tx_start[0] = 1'b0;
    observe_frame(0, 8'h3C, 0, 1'b0);

    // Start during DATA is ignored
    start_frame(0, 8'hFF);
    observe_frame(0, 8'hFF, 10, 1'b0);
    idle_check(0, 3 * CPB, "ignore_data_start");

    // Start pulsed only in the TX_Done cycle is ignored
    start_frame(0, 8'h81);
    observe_frame(0, 8'h81, (10 + PAR_BITS) * CPB, 1'b0);
    idle_check(0, 3 * CPB, "ignore_done_start");

    // Parity-relevant patterns (odd and even ones count)
    start_frame(0, 8'h07);
    observe_frame(0, 8'h07, 0, 1'b0);
    start_frame(0, 8'h03);
    observe_frame(0, 8'h03, 0, 1'b0);

    // Two stop bits
    start_frame(1, 8'h55);
    observe_frame(1, 8'h55, 0, 1'b0);

    // Asynchronous reset in the middle of DATA
    start_frame(0, 8'h00);
    repeat (11) begin
      @(posedge clk); #1;
    end
    check("pre_reset_line", 32'(line[0]), 0);
    reset_b = 1'b0;
    #1;
    reset_values("midrst");
    @(posedge clk); #1;
    reset_b = 1'b1;
    @(posedge clk); #1;
    start_frame(0, 8'h5A);
    observe_frame(0, 8'h5A, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
